// File: rtl/systolic_array_os.sv
// rtl/systolic_array_os.sv - NxN output-stationary systolic matrix multiplier, C = A * B.
// Operand lanes are skewed on entry; each PE accumulates its C element, rows drain one per cycle.
module systolic_array_os #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int K_MAX  = 256,
  localparam int KW    = $clog2(K_MAX + 1),
  localparam int IW    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   data_in,
  input  logic [N*DATA_W-1:0]   weight_in,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [IW-1:0]         result_idx,
  output logic [N*ACC_W-1:0]    result_row,
  output logic                  done
);

  localparam int FW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k_reg, beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic [IW-1:0] row_cnt;
  logic          done_nxt, clear, accept, last_beat, last_row;

  logic [DATA_W-1:0] a_edge [N];
  logic [DATA_W-1:0] b_edge [N];
  logic              at_edge [N];
  logic              bt_edge [N];

  logic [DATA_W-1:0] a_in  [N][N];
  logic [DATA_W-1:0] b_in  [N][N];
  logic              at_in [N][N];
  logic              bt_in [N][N];
  logic [ACC_W-1:0]  acc   [N][N];

  assign in_ready     = (state == LOAD);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DRAIN);
  assign result_idx   = row_cnt;
  assign accept       = in_valid & in_ready;
  assign last_beat    = accept && ((beat_cnt + KW'(1)) == k_reg);
  assign last_row     = result_ready && (row_cnt == IW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = (k_len == '0) ? DRAIN : LOAD;
        end
      end
      LOAD:  if (last_beat) state_nxt = FLUSH;
      // Last beat needs 2N-2 hops plus one accumulate edge to settle in PE(N-1,N-1).
      FLUSH: if (flush_cnt == FW'(2 * N - 2)) state_nxt = DRAIN;
      DRAIN: begin
        if (last_row) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_cnt   <= '0;
    end else begin
      if (clear) begin
        k_reg     <= k_len;
        beat_cnt  <= '0;
        flush_cnt <= '0;
        row_cnt   <= '0;
      end
      if (accept) beat_cnt <= beat_cnt + KW'(1);
      if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
      if (state == DRAIN && result_ready) row_cnt <= last_row ? '0 : row_cnt + IW'(1);
    end
  end

  // Lane g enters the array g cycles late so A and B meet diagonally.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_lane0
      assign a_edge[0]  = data_in[DATA_W-1:0];
      assign b_edge[0]  = weight_in[DATA_W-1:0];
      assign at_edge[0] = accept;
      assign bt_edge[0] = accept;
    end else begin : g_lane
      logic [DATA_W-1:0] a_d [gi];
      logic [DATA_W-1:0] b_d [gi];
      logic              a_t [gi];
      logic              b_t [gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < gi; d++) begin
            a_d[d] <= '0;
            b_d[d] <= '0;
            a_t[d] <= 1'b0;
            b_t[d] <= 1'b0;
          end
        end else begin
          a_d[0] <= data_in[gi*DATA_W +: DATA_W];
          b_d[0] <= weight_in[gi*DATA_W +: DATA_W];
          a_t[0] <= accept;
          b_t[0] <= accept;
          for (int d = 1; d < gi; d++) begin
            a_d[d] <= a_d[d-1];
            b_d[d] <= b_d[d-1];
            a_t[d] <= a_t[d-1];
            b_t[d] <= b_t[d-1];
          end
        end
      end

      assign a_edge[gi]  = a_d[gi-1];
      assign b_edge[gi]  = b_d[gi-1];
      assign at_edge[gi] = a_t[gi-1];
      assign bt_edge[gi] = b_t[gi-1];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_pe
      logic [2*DATA_W-1:0] a_x, b_x, prod;
      logic [ACC_W-1:0]    prod_ext;
      logic [ACC_W-1:0]    acc_q;

      if (gj == 0) begin : g_a_edge
        assign a_in[gi][0]  = a_edge[gi];
        assign at_in[gi][0] = at_edge[gi];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in[0][gj]  = b_edge[gj];
        assign bt_in[0][gj] = bt_edge[gj];
      end

      assign a_x  = {{DATA_W{a_in[gi][gj][DATA_W-1]}}, a_in[gi][gj]};
      assign b_x  = {{DATA_W{b_in[gi][gj][DATA_W-1]}}, b_in[gi][gj]};
      assign prod = a_x * b_x;

      if (ACC_W > 2 * DATA_W) begin : g_ext
        assign prod_ext = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
      end else begin : g_noext
        assign prod_ext = prod;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_q <= '0;
        end else if (clear) begin
          acc_q <= '0;
        end else if (at_in[gi][gj] && bt_in[gi][gj]) begin
          acc_q <= acc_q + prod_ext;
        end
      end
      assign acc[gi][gj] = acc_q;

      if (gj < N - 1) begin : g_pass_a
        logic [DATA_W-1:0] a_q;
        logic              at_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            a_q  <= '0;
            at_q <= 1'b0;
          end else begin
            a_q  <= a_in[gi][gj];
            at_q <= at_in[gi][gj];
          end
        end
        assign a_in[gi][gj+1]  = a_q;
        assign at_in[gi][gj+1] = at_q;
      end

      if (gi < N - 1) begin : g_pass_b
        logic [DATA_W-1:0] b_q;
        logic              bt_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            b_q  <= '0;
            bt_q <= 1'b0;
          end else begin
            b_q  <= b_in[gi][gj];
            bt_q <= bt_in[gi][gj];
          end
        end
        assign b_in[gi+1][gj]  = b_q;
        assign bt_in[gi+1][gj] = bt_q;
      end
    end
  end

  always_comb begin
    result_row = '0;
    for (int j = 0; j < N; j++) begin
      result_row[j*ACC_W +: ACC_W] = acc[row_cnt][j];
    end
  end

endmodule

// File: tb/tb_systolic_array_os.sv
// tb/tb_systolic_array_os.sv - directed bench for systolic_array_os (N=4, 16-bit operands, 32-bit results).
module tb_systolic_array_os;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int KM = 16;
  localparam int KW = $clog2(KM + 1);
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*DW-1:0]   data_in = '0;
  logic [N*DW-1:0]   weight_in = '0;
  logic              busy;
  logic              result_valid;
  logic              result_ready = 1'b1;
  logic [IW-1:0]     result_idx;
  logic [N*AW-1:0]   result_row;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] am [N][8];
  logic signed [DW-1:0] bm [8][N];
  logic [AW-1:0]        ec [N][N];

  always #5 clk = ~clk;

  systolic_array_os #(.N(N), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .weight_in(weight_in),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_idx(result_idx), .result_row(result_row), .done(done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mats();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 8; k++) begin
        am[i][k] = '0;
        bm[k][i] = '0;
      end
      for (int j = 0; j < N; j++) ec[i][j] = '0;
    end
  endtask

  task automatic load_t1();
    clear_mats();
    am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
    bm[0][0] = 5; bm[0][1] = 6; bm[1][0] = 7; bm[1][1] = 8;
    ec[0][0] = 19; ec[0][1] = 22; ec[1][0] = 43; ec[1][1] = 50;
  endtask

  task automatic start_job(input int k);
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
    k_len = '0;
  endtask

  task automatic send_beats(input int k, input bit bubble, input int spurious_at, input bit chk_flush);
    int cyc = 0;
    int nacc = 0;
    int fl = 0;
    bit ready_seen = 1'b0;
    while (nacc < k && cyc < 200) begin
      in_valid = bubble ? (cyc % 2 == 0) : 1'b1;
      for (int i = 0; i < N; i++) begin
        data_in[i*DW +: DW]   = am[i][nacc];
        weight_in[i*DW +: DW] = bm[nacc][i];
      end
      start = (cyc == spurious_at);
      k_len = KW'(1);
      if (in_valid && in_ready) nacc++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    k_len = '0;
    data_in = '0;
    weight_in = '0;
    chk("beats_accepted", nacc, k);
    if (chk_flush) begin
      while (!result_valid && fl < 50) begin
        if (in_ready !== 1'b0) ready_seen = 1'b1;
        tick();
        fl++;
      end
      chk("flush_len", fl, 2 * N - 1);
      chk("flush_in_ready_low", ready_seen, 1'b0);
    end
  endtask

  task automatic drain(input int stall_row, input int stall_n);
    int seen = 0;
    int cyc = 0;
    int left = stall_n;
    logic [127:0] erow;
    while (seen < N && cyc < 100) begin
      if (result_valid) begin
        erow = '0;
        for (int j = 0; j < N; j++) erow[j*AW +: AW] = ec[seen][j];
        if (seen == stall_row && left > 0) begin
          result_ready = 1'b0;
          chk("stall_idx", result_idx, seen);
          chk("stall_row", result_row, erow);
          left--;
        end else begin
          result_ready = 1'b1;
          chk("row_idx", result_idx, seen);
          chk("row_data", result_row, erow);
          seen++;
        end
      end else begin
        result_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    result_ready = 1'b1;
    chk("rows_drained", seen, N);
    chk("done_pulse", done, 1'b1);
    chk("busy_after_drain", busy, 1'b0);
  endtask

  initial begin
    clear_mats();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_result_valid", result_valid, 1'b0);
    chk("reset_result_idx", result_idx, 0);
    chk("reset_done", done, 1'b0);

    // 2x2 product in the top-left corner, no bubbles
    load_t1();
    start_job(2);
    chk("load_busy", busy, 1'b1);
    send_beats(2, 1'b0, -1, 1'b1);
    drain(-1, 0);
    tick();
    chk("done_one_cycle", done, 1'b0);

    // identity times 1..16 with alternating bubbles and a stray start in LOAD
    clear_mats();
    for (int i = 0; i < N; i++) begin
      am[i][i] = 1;
      for (int j = 0; j < N; j++) begin
        bm[i][j] = DW'(i * N + j + 1);
        ec[i][j] = AW'(i * N + j + 1);
      end
    end
    start_job(4);
    send_beats(4, 1'b1, 2, 1'b1);
    drain(-1, 0);

    // signed extremes wrap, small negative product, backpressure on row 1
    clear_mats();
    am[0][0] = -16'sd32768; am[0][1] = -16'sd32768; am[1][0] = -16'sd3;
    bm[0][0] = -16'sd32768; bm[1][0] = -16'sd32768; bm[0][1] = 16'sd5;
    ec[0][0] = 32'h8000_0000; ec[0][1] = 32'hFFFD_8000;
    ec[1][0] = 32'h0001_8000; ec[1][1] = 32'hFFFF_FFF1;
    start_job(2);
    send_beats(2, 1'b0, -1, 1'b0);
    drain(1, 3);

    // k_len=0 started back-to-back in the done cycle
    clear_mats();
    start_job(0);
    chk("k0_skip_load_valid", result_valid, 1'b1);
    chk("k0_in_ready", in_ready, 1'b0);
    drain(-1, 0);

    // reset mid-LOAD, then a fresh job
    load_t1();
    start_job(4);
    send_beats(2, 1'b0, -1, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_result_valid", result_valid, 1'b0);
    chk("abort_done", done, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_no_done", done, 1'b0);
    start_job(2);
    send_beats(2, 1'b0, -1, 1'b1);
    drain(-1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
